// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-prediction entry type, resolve FSM states and instruction size
package bp_pkg;
  localparam int BP_MAX_ADDR = 64;
  localparam int INSN_BYTES = 4;
  typedef struct packed {
    logic                   valid;
    logic [BP_MAX_ADDR-1:0] pc;
    logic                   taken;
    logic [BP_MAX_ADDR-1:0] target;
  } pred_entry_t;
  typedef enum logic {RS_IDLE, RS_REDIRECT} resolve_state_t;
endpackage

// File: rtl/pred_pipe_reg.sv
// pred_pipe_reg: one prediction pipeline register; flush clears, stall holds, else loads
// Ports: clk, rst (async, active-high), stall_i, flush_i, d_i (next entry), q_o (held entry)
module pred_pipe_reg
  import bp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  pred_entry_t d_i,
  output pred_entry_t q_o
);
  pred_entry_t q_q, q_d;
  always_comb q_d = flush_i ? '0 : stall_i ? q_q : d_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: checks IF-stage predictions against EXE outcomes, trains the predictor, redirects fetch
// Ports: clk, rst (async, active-high); IF prediction pc_if/jump_if/pc_target_if/if_valid;
//   stall_id/stall_exe hold the IF/ID and ID/EXE registers; EXE outcome exe_valid/pc_exe/is_jump_exe/
//   jump_exe/pc_target_exe; training upd_*; fetch redirect handshake redirect_valid/redirect_pc/
//   redirect_ready; squash flush_id/flush_exe.
// Optional: BRANCH_RESOLVE_STATS_EN adds saturating stat_branches/stat_mispredicts counters.
module branch_resolve
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_if,
  input  logic                  jump_if,
  input  logic [ADDR_WIDTH-1:0] pc_target_if,
  input  logic                  if_valid,
  input  logic                  stall_id,
  input  logic                  stall_exe,
  input  logic                  exe_valid,
  input  logic [ADDR_WIDTH-1:0] pc_exe,
  input  logic                  is_jump_exe,
  input  logic                  jump_exe,
  input  logic [ADDR_WIDTH-1:0] pc_target_exe,
  output logic                  upd_valid,
  output logic [ADDR_WIDTH-1:0] upd_pc,
  output logic [ADDR_WIDTH-1:0] upd_target,
  output logic                  upd_taken,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  redirect_ready,
  output logic                  flush_id,
  output logic                  flush_exe
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  resolve_state_t state_q, state_d;
  pred_entry_t if_entry, ifid_q, idexe_d, idexe_q;
  addr_t pred_pc, pred_target, correct_pc, redirect_pc_q, redirect_pc_d;
  addr_t upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
  logic upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic resolve, train, mispredict, flush;
  always_comb begin
    if_entry = '{valid: if_valid, pc: BP_MAX_ADDR'(pc_if), taken: jump_if,
                 target: BP_MAX_ADDR'(pc_target_if)};
    idexe_d = ifid_q;
    idexe_d.valid = ifid_q.valid && !stall_id;
  end
  pred_pipe_reg u_ifid (
    .clk(clk), .rst(rst), .stall_i(stall_id), .flush_i(flush), .d_i(if_entry), .q_o(ifid_q)
  );
  pred_pipe_reg u_idexe (
    .clk(clk), .rst(rst), .stall_i(stall_exe), .flush_i(flush), .d_i(idexe_d), .q_o(idexe_q)
  );
  always_comb begin
    pred_pc = addr_t'(idexe_q.pc);
    pred_target = addr_t'(idexe_q.target);
    resolve = exe_valid && idexe_q.valid && state_q == RS_IDLE;
    train = resolve && is_jump_exe;
    // a pc mismatch means the predicted path is wrong, so it redirects like any other mispredict
    mispredict = resolve && ((pc_exe != pred_pc)
               || (is_jump_exe ? idexe_q.taken != jump_exe : idexe_q.taken)
               || (idexe_q.taken && jump_exe && pred_target != pc_target_exe));
    correct_pc = jump_exe ? pc_target_exe : pc_exe + addr_t'(INSN_BYTES);
    flush = mispredict || state_q == RS_REDIRECT;
    state_d = mispredict ? RS_REDIRECT
            : (state_q == RS_REDIRECT && redirect_ready) ? RS_IDLE : state_q;
    redirect_pc_d = mispredict ? correct_pc : redirect_pc_q;
    upd_valid_d = train;
    upd_pc_d = train ? pc_exe : upd_pc_q;
    upd_target_d = train ? pc_target_exe : upd_target_q;
    upd_taken_d = train ? jump_exe : upd_taken_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RS_IDLE;
      redirect_pc_q <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q <= '0;
      upd_target_q <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      redirect_pc_q <= redirect_pc_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q <= upd_pc_d;
      upd_target_q <= upd_target_d;
      upd_taken_q <= upd_taken_d;
    end
  assign upd_valid = upd_valid_q;
  assign upd_pc = upd_pc_q;
  assign upd_target = upd_target_q;
  assign upd_taken = upd_taken_q;
  assign redirect_valid = state_q == RS_REDIRECT;
  assign redirect_pc = redirect_pc_q;
  assign flush_id = flush;
  assign flush_exe = flush;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;
  always_comb begin
    stat_br_d = (train && ~&stat_br_q) ? stat_br_q + 32'd1 : stat_br_q;
    stat_mis_d = (mispredict && ~&stat_mis_q) ? stat_mis_q + 32'd1 : stat_mis_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_br_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  assign stat_branches = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`endif
endmodule
